alu_16bit: RTL and testbench

ALU_16BIT -- requirements
Module: alu_16bit

---
 rtl/alu_16bit_pkg.sv | 16 +
 rtl/alu_16bit_core.sv | 52 +++++
 rtl/alu_16bit.sv | 69 ++++++
 tb/tb_alu_16bit.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_16bit_pkg.sv
// Shared opcode encoding and default width for the alu_16bit block.
`timescale 1ns/1ps
package alu_16bit_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // Encodings not listed here (100, 101, 110) are reserved and flagged illegal.
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b111
  } op_e;

endpackage

// File: rtl/alu_16bit_core.sv
// Purely combinational ALU datapath: result and flags from a, b and sel.
`timescale 1ns/1ps
module alu_16bit_core
  import alu_16bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic             illegal_op
);

  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;

  // One extra bit holds the add carry-out or the subtract borrow.
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    result     = '0;
    carry      = 1'b0;
    overflow   = 1'b0;
    illegal_op = 1'b0;
    case (op_e'(sel))
      OP_ADD: begin
        result   = sum_ext[WIDTH-1:0];
        carry    = sum_ext[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result   = diff_ext[WIDTH-1:0];
        carry    = diff_ext[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      default: illegal_op = 1'b1;
    endcase
  end

  assign zero     = (result == '0);
  assign negative = result[WIDTH-1];

endmodule

// File: rtl/alu_16bit.sv
// Registered ALU: captures A/B/sel when in_valid is high, result one cycle later.
`timescale 1ns/1ps
module alu_16bit
  import alu_16bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] C,
  output logic             out_valid,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic             illegal_op
);

  // Handshake: in_valid qualifies A/B/sel at a rising edge; there is no ready,
  // every qualified input is accepted, and out_valid pulses for exactly one
  // cycle with its result. Outputs hold their last value when no input arrives.

  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_carry;
  logic             core_overflow;
  logic             core_negative;
  logic             core_illegal;

  alu_16bit_core #(.WIDTH(WIDTH)) u_core (
    .a          (A),
    .b          (B),
    .sel        (sel),
    .result     (core_result),
    .zero       (core_zero),
    .carry      (core_carry),
    .overflow   (core_overflow),
    .negative   (core_negative),
    .illegal_op (core_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      C          <= '0;
      out_valid  <= 1'b0;
      zero       <= 1'b0;
      carry      <= 1'b0;
      overflow   <= 1'b0;
      negative   <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Gating on in_valid keeps X/Z on idle inputs out of the registers.
      if (in_valid) begin
        C          <= core_result;
        zero       <= core_zero;
        carry      <= core_carry;
        overflow   <= core_overflow;
        negative   <= core_negative;
        illegal_op <= core_illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_16bit.sv
// Self-checking bench for alu_16bit: directed corner cases plus randomized traffic.
`timescale 1ns/1ps
module tb_alu_16bit;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [2:0]   sel;
  logic [W-1:0] c_out;
  logic         out_valid;
  logic         zero;
  logic         carry;
  logic         overflow;
  logic         negative;
  logic         illegal_op;

  int tests_run;
  int tests_failed;

  // Packed expectation: {illegal_op, negative, overflow, carry, zero, C}
  logic [W+4:0] exp_q[$];

  alu_16bit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .A          (a_in),
    .B          (b_in),
    .sel        (sel),
    .C          (c_out),
    .out_valid  (out_valid),
    .zero       (zero),
    .carry      (carry),
    .overflow   (overflow),
    .negative   (negative),
    .illegal_op (illegal_op)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W+4:0] observed();
    return {illegal_op, negative, overflow, carry, zero, c_out};
  endfunction

  // Reference model: integer arithmetic on unsigned and signed interpretations.
  function automatic logic [W+4:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] s);
    int ua, ub, sa, sb, full, sres;
    logic [W-1:0] c;
    logic cy, ov, il;
    ua = int'(a);
    ub = int'(b);
    sa = a[W-1] ? ua - 65536 : ua;
    sb = b[W-1] ? ub - 65536 : ub;
    c = '0; cy = 1'b0; ov = 1'b0; il = 1'b0;
    case (s)
      3'b000: begin
        full = ua + ub;
        c    = full[W-1:0];
        cy   = (full > 65535);
        sres = sa + sb;
        ov   = (sres > 32767) || (sres < -32768);
      end
      3'b001: begin
        full = ua - ub;
        c    = full[W-1:0];
        cy   = (ua < ub);
        sres = sa - sb;
        ov   = (sres > 32767) || (sres < -32768);
      end
      3'b010: c = a & b;
      3'b011: c = a | b;
      3'b111: c = a ^ b;
      default: il = 1'b1;
    endcase
    return {il, c[W-1], ov, cy, (c == 0), c};
  endfunction

  // Driver tasks
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] s);
    in_valid = v;
    a_in     = a;
    b_in     = b;
    sel      = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, '0, '0, 3'b000);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 16'hFFFF, 16'h0001, 3'b000);
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (observed() !== '0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got out_valid=%b flags/C=%h, expected 0/0", out_valid, observed());
    end
    rst = 1'b0;
    drive(1'b0, '0, '0, 3'b000);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || c_out !== '0) begin
      tests_failed++;
      $display("FAIL reset_release_idle: got out_valid=%b C=%h, expected 0/0000", out_valid, c_out);
    end
  endtask

  task automatic test_add();
    drive(1'b1, 16'hFFFF, 16'h0001, 3'b000);
    @(negedge clk);
    drive(1'b0, '0, '0, 3'b000);
    tests_run++;
    if (c_out !== 16'h0000 || zero !== 1'b1 || carry !== 1'b1 || overflow !== 1'b0 ||
        out_valid !== 1'b1 || illegal_op !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_wrap: got C=%h z=%b c=%b v=%b ov=%b il=%b, expected C=0000 z=1 c=1 v=1 ov=0 il=0",
               c_out, zero, carry, out_valid, overflow, illegal_op);
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || c_out !== 16'h0000 || carry !== 1'b1) begin
      tests_failed++;
      $display("FAIL add_hold: got v=%b C=%h c=%b, expected v=0 C=0000 c=1", out_valid, c_out, carry);
    end
  endtask

  task automatic test_sub();
    drive(1'b1, 16'h8000, 16'h0001, 3'b001);
    @(negedge clk);
    drive(1'b0, '0, '0, 3'b000);
    tests_run++;
    if (c_out !== 16'h7FFF || overflow !== 1'b1 || carry !== 1'b0 || negative !== 1'b0 ||
        zero !== 1'b0 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL sub_overflow: got C=%h ov=%b c=%b n=%b z=%b v=%b, expected C=7fff ov=1 c=0 n=0 z=0 v=1",
               c_out, overflow, carry, negative, zero, out_valid);
    end
    drive(1'b1, 16'h0001, 16'h0002, 3'b001);
    @(negedge clk);
    drive(1'b0, '0, '0, 3'b000);
    tests_run++;
    if (c_out !== 16'hFFFF || carry !== 1'b1 || negative !== 1'b1 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL sub_borrow: got C=%h c=%b n=%b ov=%b, expected C=ffff c=1 n=1 ov=0",
               c_out, carry, negative, overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_c[3];
    logic [2:0]   ops[3];
    exp_c[0] = 16'h00F0; exp_c[1] = 16'hFFF0; exp_c[2] = 16'hFF00;
    ops[0] = 3'b010; ops[1] = 3'b011; ops[2] = 3'b111;
    drive(1'b1, 16'hF0F0, 16'h0FF0, ops[0]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) drive(1'b1, 16'hF0F0, 16'h0FF0, ops[i+1]);
      else drive(1'b0, '0, '0, 3'b000);
      tests_run++;
      if (c_out !== exp_c[i] || out_valid !== 1'b1 || carry !== 1'b0 || overflow !== 1'b0 ||
          illegal_op !== 1'b0) begin
        tests_failed++;
        $display("FAIL logic_op_%0d: got C=%h v=%b c=%b ov=%b il=%b, expected C=%h v=1 c=0 ov=0 il=0",
                 i, c_out, out_valid, carry, overflow, illegal_op, exp_c[i]);
      end
    end
  endtask

  task automatic test_reserved();
    logic [2:0] rsv[3];
    rsv[0] = 3'b101; rsv[1] = 3'b100; rsv[2] = 3'b110;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h1234, 16'h5678, rsv[i]);
      @(negedge clk);
      drive(1'b0, '0, '0, 3'b000);
      tests_run++;
      if (c_out !== 16'h0000 || illegal_op !== 1'b1 || zero !== 1'b1 || carry !== 1'b0 ||
          overflow !== 1'b0 || negative !== 1'b0 || out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL reserved_op_%0d: got C=%h il=%b z=%b c=%b ov=%b n=%b v=%b, expected C=0000 il=1 z=1 c=0 ov=0 n=0 v=1",
                 rsv[i], c_out, illegal_op, zero, carry, overflow, negative, out_valid);
      end
    end
  endtask

  task automatic test_sampling();
    drive(1'b1, 16'h0003, 16'h0004, 3'b000);
    @(posedge clk);
    #1;
    drive(1'b1, 16'hAAAA, 16'h5555, 3'b011);
    #1;
    drive(1'b0, 'x, 'x, 3'bxxx);
    @(negedge clk);
    tests_run++;
    if (c_out !== 16'h0007 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL edge_sampling: got C=%h v=%b, expected C=0007 v=1", c_out, out_valid);
    end
    @(negedge clk);
    tests_run++;
    if (c_out !== 16'h0007 || out_valid !== 1'b0 || zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_x_hold: got C=%h v=%b z=%b, expected C=0007 v=0 z=0", c_out, out_valid, zero);
    end
    drive(1'b0, '0, '0, 3'b000);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 16'h1111, 16'h2222, 3'b000);
    @(negedge clk);
    drive(1'b1, 16'h4444, 16'h1111, 3'b000);
    tests_run++;
    if (out_valid !== 1'b1 || c_out !== 16'h3333) begin
      tests_failed++;
      $display("FAIL pre_reset_result: got C=%h v=%b, expected C=3333 v=1", c_out, out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || c_out !== 16'h0000 || zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_clear: got C=%h v=%b z=%b, expected C=0000 v=0 z=0", c_out, out_valid, zero);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, '0, '0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0 || c_out !== 16'h0000) begin
        tests_failed++;
        $display("FAIL no_pulse_after_reset_%0d: got C=%h v=%b, expected C=0000 v=0", i, c_out, out_valid);
      end
    end
    drive(1'b1, 16'h0005, 16'h0003, 3'b001);
    @(negedge clk);
    drive(1'b0, '0, '0, 3'b000);
    tests_run++;
    if (out_valid !== 1'b1 || c_out !== 16'h0002) begin
      tests_failed++;
      $display("FAIL first_capture: got C=%h v=%b, expected C=0002 v=1", c_out, out_valid);
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic test_random();
    logic [W+4:0] last;
    logic [W+4:0] exp;
    logic         exp_valid;
    logic         v;
    logic [W-1:0] a, b;
    logic [2:0]   s;
    do_reset();
    exp_q.delete();
    last = '0;
    exp_valid = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== exp_valid) begin
        tests_failed++;
        $display("FAIL rand_valid[%0d]: got out_valid=%b, expected %b", n, out_valid, exp_valid);
      end
      if (exp_valid) begin
        if (exp_q.size() == 0) begin
          exp = last;
        end else begin
          exp  = exp_q.pop_front();
          last = exp;
        end
      end else begin
        exp = last;
      end
      tests_run++;
      if (observed() !== exp) begin
        tests_failed++;
        $display("FAIL rand_result[%0d]: got il/n/ov/c/z/C=%h, expected %h", n, observed(), exp);
      end
      v = ($urandom_range(0, 3) != 0);
      a = pick_operand();
      b = pick_operand();
      s = 3'($urandom_range(0, 7));
      drive(v, a, b, s);
      if (v) exp_q.push_back(model(a, b, s));
      exp_valid = v;
    end
    @(negedge clk);
    drive(1'b0, '0, '0, 3'b000);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    drive(1'b0, '0, '0, 3'b000);
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reserved();
    test_sampling();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
